// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Brief    : Shared opcode constants, scheduler state encodings and operand
//            usage helpers for the RV pipeline front-end sequencing logic.
// Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

    // Major opcodes whose register operands matter for hazard detection
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Scheduler state encodings (visible externally on schedState)
    localparam logic [1:0] ST_RUN        = 2'b00;
    localparam logic [1:0] ST_BR_WAIT    = 2'b01;
    localparam logic [1:0] ST_BR_RESOLVE = 2'b10;
    localparam logic [1:0] ST_EXT_HOLD   = 2'b11;

    // Instruction formats that actually read rs1
    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    // Instruction formats that actually read rs2
    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : rv_load_use_detect
// Brief    : Combinational load-use hazard detector. Flags when the load in EX
//            writes a non-zero register that the instruction in ID reads.
// Revision : 1.0 - initial release
// ============================================================================
module rv_load_use_detect
    import rv_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_mem_read,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // Only fields the ID instruction genuinely reads may create a hazard;
    // x0 is never a real producer.
    always_comb begin
        w_rs1_hit  = uses_rs1(i_opcode) && (i_ex_rd == i_rs1);
        w_rs2_hit  = uses_rs2(i_opcode) && (i_ex_rd == i_rs2);
        o_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_scheduler
// Brief    : Front-end sequencing controller beside ID. Arbitrates external
//            hold, load-use and ID-resolved branch stalls, drives PC/IF_ID
//            hold, ID/EX bubble, IF_ID flush and PC-source select, and keeps
//            saturating stall/flush statistics.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_scheduler
    import rv_pkg::*;
#(
    parameter int BR_WAIT_CYCLES = 2,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      IF_ID_Instr,
    input  logic [4:0]       ID_Ex_Rd,
    input  logic             ID_ExMemRead,
    input  logic             ID_branchTaken,
    input  logic             extStallReq,
    output logic             holdPC,
    output logic             holdIF_ID,
    output logic             muxSelector,
    output logic             flushIF_ID,
    output logic             pcSrc,
    output logic [1:0]       schedState,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam int                c_WAIT_W    = $clog2(BR_WAIT_CYCLES + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_INIT = c_WAIT_W'(BR_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_next_wait;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic                w_load_use;
    logic                w_is_branch;
    logic                w_hold;
    logic                w_flush;
    logic                w_unused;

    // Immediate / funct / rd bits play no part in scheduling
    assign w_unused    = ^{IF_ID_Instr[31:25], IF_ID_Instr[14:7]};
    assign w_is_branch = (IF_ID_Instr[6:0] == OP_BRANCH);

    rv_load_use_detect u_load_use (
        .i_opcode      (IF_ID_Instr[6:0]),
        .i_rs1         (IF_ID_Instr[19:15]),
        .i_rs2         (IF_ID_Instr[24:20]),
        .i_ex_rd       (ID_Ex_Rd),
        .i_ex_mem_read (ID_ExMemRead),
        .o_load_use    (w_load_use)
    );

    // Mealy output decode and next-state logic; reset masks every control output
    always_comb begin
        w_hold       = 1'b0;
        w_flush      = 1'b0;
        w_next_state = r_state;
        w_next_wait  = r_wait_cnt;
        case (r_state)
            ST_BR_WAIT: begin
                w_hold = 1'b1;
                if (!extStallReq) begin
                    if (r_wait_cnt == '0) begin
                        w_next_state = ST_BR_RESOLVE;
                    end else begin
                        w_next_wait = r_wait_cnt - c_WAIT_W'(1);
                    end
                end
            end
            ST_BR_RESOLVE: begin
                if (extStallReq) begin
                    w_hold = 1'b1;
                end else begin
                    w_flush      = ID_branchTaken;
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                // RUN and EXT_HOLD share arbitration: EXT_HOLD just re-enters
                // itself while the external request persists.
                if (extStallReq) begin
                    w_hold       = 1'b1;
                    w_next_state = ST_EXT_HOLD;
                end else if (w_load_use) begin
                    w_hold       = 1'b1;
                    w_next_state = ST_RUN;
                end else if (w_is_branch) begin
                    w_hold       = 1'b1;
                    w_next_wait  = c_WAIT_INIT;
                    w_next_state = ST_BR_WAIT;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
        endcase
        if (reset) begin
            w_hold  = 1'b0;
            w_flush = 1'b0;
        end
    end

    // State and branch-settle counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hold && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign holdPC      = w_hold;
    assign holdIF_ID   = w_hold;
    assign muxSelector = w_hold;
    assign flushIF_ID  = w_flush;
    assign pcSrc       = w_flush;
    assign schedState  = r_state;
    assign stallCount  = r_stall_cnt;
    assign flushCount  = r_flush_cnt;

endmodule
`default_nettype wire
